// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the pin signals, then
// deframes 11-bit frames into scan-code bytes with parity/stop/timeout checks.
module ps2_keyboard_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] data,
  output logic       data_en,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [FW-1:0] FiltLast = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT_CYCLES - 1);

  if (FILTER_LEN < 2) begin : g_bad_filter
    $error("FILTER_LEN must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [0:0] {
    StIdle,
    StRecv
  } state_e;

  // Pin synchronizers
  logic clk_meta, clk_sync;
  logic dat_meta, dat_sync;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= PS2_CLK;
      clk_sync <= clk_meta;
      dat_meta <= PS2_DAT;
      dat_sync <= dat_meta;
    end
  end

  // Glitch filter: the filtered clock only follows a level held FILTER_LEN cycles
  logic [FW-1:0] filt_cnt;
  logic          clk_filt;
  logic          clk_filt_prev;
  logic          fall;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      filt_cnt <= '0;
      clk_filt <= 1'b1;
    end else if (clk_sync != clk_filt) begin
      if (filt_cnt == FiltLast) begin
        clk_filt <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      clk_filt_prev <= 1'b1;
      fall          <= 1'b0;
    end else begin
      clk_filt_prev <= clk_filt;
      fall          <= clk_filt_prev & ~clk_filt;
    end
  end

  // Frame deserializer with registered result strobes
  state_e        state;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    shift;
  logic          par_bit;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= StIdle;
      bit_cnt    <= 4'd0;
      tmo_cnt    <= '0;
      shift      <= 8'h00;
      par_bit    <= 1'b0;
      data       <= 8'h00;
      data_en    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_en    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        StIdle: begin
          // A high bit on a fall is a false start and is silently ignored
          if (fall && !dat_sync) begin
            state   <= StRecv;
            bit_cnt <= 4'd1;
            tmo_cnt <= '0;
          end
        end
        StRecv: begin
          if (fall) begin
            tmo_cnt <= '0;
            if (bit_cnt <= 4'd8) begin
              shift   <= {dat_sync, shift[7:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd9) begin
              par_bit <= dat_sync;
              bit_cnt <= 4'd10;
            end else begin
              state   <= StIdle;
              bit_cnt <= 4'd0;
              if (!dat_sync) begin
                frame_err <= 1'b1;
              end else if (!(^{shift, par_bit})) begin
                parity_err <= 1'b1;
              end else begin
                data    <= shift;
                data_en <= 1'b1;
              end
            end
          end else if (tmo_cnt == TmoLast) begin
            frame_err <= 1'b1;
            state     <= StIdle;
            bit_cnt   <= 4'd0;
            tmo_cnt   <= '0;
            shift     <= 8'h00;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
